// File: rtl/count_wrap_tracker.sv
// count_wrap_tracker: extends a 4-bit up/down counter with a high-order wrap counter and
// flags illegal or misdirected steps. Define COUNT_WRAP_TRACKER_STALL_EN for stall detection.
module count_wrap_tracker #(
  parameter int HI_WIDTH    = 8,
  parameter int STALL_LIMIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                updown,
  input  logic [3:0]          count_in,
  output logic                carry_out,
  output logic                borrow_out,
  output logic                step_err,
  output logic                dir_err,
  output logic [HI_WIDTH-1:0] hi_count,
  output logic [HI_WIDTH+3:0] full_count,
  output logic                valid,
  output logic                stalled
);

`ifdef COUNT_WRAP_TRACKER_STALL_EN
  typedef enum logic [1:0] {INIT, TRACK, STALL} state_t;
`else
  typedef enum logic [0:0] {INIT, TRACK} state_t;
`endif

  state_t state_q, state_d;

  logic [3:0]          prev_q;
  logic                dir_q;
  logic [HI_WIDTH-1:0] hi_q, hi_d;
  logic                carry_q, carry_d;
  logic                borrow_q, borrow_d;
  logic                step_err_q, step_err_d;
  logic                dir_err_q, dir_err_d;
  logic                valid_q;
  logic                stalled_q, stalled_d;

  // Modular difference between the new sample and the previous one classifies the step.
  logic [3:0] delta;
  logic       is_same, is_up, is_down, tracking;

  assign delta    = count_in - prev_q;
  assign is_same  = (delta == 4'd0);
  assign is_up    = (delta == 4'd1);
  assign is_down  = (delta == 4'd15);
  assign tracking = (state_q != INIT);

`ifdef COUNT_WRAP_TRACKER_STALL_EN
  localparam logic [7:0] RUN_TARGET = 8'(STALL_LIMIT - 1);

  logic [7:0] run_q, run_d, run_inc;
  logic       stall_hit;

  assign run_inc   = (run_q == 8'hFF) ? 8'hFF : run_q + 8'd1;
  assign stall_hit = is_same && (run_inc >= RUN_TARGET);

  always_comb begin
    run_d = 8'd0;
    if (tracking && is_same) begin
      run_d = run_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q <= 8'd0;
    end else begin
      run_q <= run_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    state_d = TRACK;
`ifdef COUNT_WRAP_TRACKER_STALL_EN
      TRACK:   state_d = stall_hit ? STALL : TRACK;
      STALL:   state_d = is_same ? STALL : TRACK;
`else
      TRACK:   state_d = TRACK;
`endif
      default: state_d = INIT;
    endcase
  end

  // Wrap steps are still direction-checked, so a carry can coincide with dir_err.
  always_comb begin
    carry_d    = 1'b0;
    borrow_d   = 1'b0;
    step_err_d = 1'b0;
    dir_err_d  = 1'b0;
    hi_d       = hi_q;
    if (tracking) begin
      if (is_up) begin
        dir_err_d = !dir_q;
        if (prev_q == 4'hF) begin
          carry_d = 1'b1;
          hi_d    = hi_q + HI_WIDTH'(1);
        end
      end else if (is_down) begin
        dir_err_d = dir_q;
        if (prev_q == 4'h0) begin
          borrow_d = 1'b1;
          hi_d     = hi_q - HI_WIDTH'(1);
        end
      end else if (!is_same) begin
        step_err_d = 1'b1;
      end
    end
  end

`ifdef COUNT_WRAP_TRACKER_STALL_EN
  assign stalled_d = (state_d == STALL);
`else
  assign stalled_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q     <= 4'h0;
      dir_q      <= 1'b0;
      hi_q       <= '0;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      step_err_q <= 1'b0;
      dir_err_q  <= 1'b0;
      valid_q    <= 1'b0;
      stalled_q  <= 1'b0;
    end else begin
      prev_q     <= count_in;
      dir_q      <= updown;
      hi_q       <= hi_d;
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
      step_err_q <= step_err_d;
      dir_err_q  <= dir_err_d;
      valid_q    <= 1'b1;
      stalled_q  <= stalled_d;
    end
  end

  assign carry_out  = carry_q;
  assign borrow_out = borrow_q;
  assign step_err   = step_err_q;
  assign dir_err    = dir_err_q;
  assign hi_count   = hi_q;
  assign full_count = {hi_q, prev_q};
  assign valid      = valid_q;
  assign stalled    = stalled_q;

endmodule

// File: tb/tb_count_wrap_tracker.sv
// tb_count_wrap_tracker: table-driven check of wrap tracking plus hand-written
// sequences for reset, down wrap, stall detection and mid-operation reset.
module tb_count_wrap_tracker;

  logic        clk;
  logic        reset;
  logic        updown;
  logic [3:0]  count_in;
  logic        carry_out, borrow_out, step_err, dir_err, valid, stalled;
  logic [7:0]  hi_count;
  logic [11:0] full_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  cnt;
    logic        ud;
    logic        carry;
    logic        borrow;
    logic        step;
    logic        dir;
    logic [7:0]  hi;
    logic [11:0] full;
  } vec_t;

  vec_t vecs[$];

  count_wrap_tracker #(.HI_WIDTH(8), .STALL_LIMIT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .updown     (updown),
    .count_in   (count_in),
    .carry_out  (carry_out),
    .borrow_out (borrow_out),
    .step_err   (step_err),
    .dir_err    (dir_err),
    .hi_count   (hi_count),
    .full_count (full_count),
    .valid      (valid),
    .stalled    (stalled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] cnt, input logic ud);
    count_in = cnt;
    updown   = ud;
    @(posedge clk);
    #1;
  endtask

  task automatic checkPulses(input string tag, input logic c, input logic b, input logic s, input logic d);
    checkOutput({tag, " carry"}, 32'(carry_out), 32'(c));
    checkOutput({tag, " borrow"}, 32'(borrow_out), 32'(b));
    checkOutput({tag, " step_err"}, 32'(step_err), 32'(s));
    checkOutput({tag, " dir_err"}, 32'(dir_err), 32'(d));
  endtask

  task automatic addVec(input logic [3:0] cnt, input logic ud, input logic c, input logic b,
                        input logic s, input logic d, input logic [7:0] hi, input logic [11:0] full);
    vec_t v;
    v.cnt = cnt; v.ud = ud; v.carry = c; v.borrow = b;
    v.step = s; v.dir = d; v.hi = hi; v.full = full;
    vecs.push_back(v);
  endtask

  // Asserts reset between edges, checks the cleared outputs, then releases before the next edge.
  task automatic pulseReset(input logic [3:0] cnt, input logic ud);
    reset = 1'b0;
    #1;
    checkPulses("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset valid", 32'(valid), 32'd0);
    checkOutput("reset full", 32'(full_count), 32'd0);
    count_in = cnt;
    updown   = ud;
    #1;
    reset = 1'b1;
    #1;
    checkOutput("pre-init valid", 32'(valid), 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    updown   = 1'b1;
    count_in = 4'h3;

    // Hold 0x3, up sweep with carry, jump, direction errors, wrap + dir_err corners.
    for (int i = 0; i < 3; i++) addVec(4'h3, 1'b1, 0, 0, 0, 0, 8'h00, 12'h003);
    for (int i = 4; i < 16; i++) addVec(4'(i), 1'b1, 0, 0, 0, 0, 8'h00, 12'(i));
    addVec(4'h0, 1'b1, 1, 0, 0, 0, 8'h01, 12'h010);
    addVec(4'h1, 1'b1, 0, 0, 0, 0, 8'h01, 12'h011);
    for (int i = 2; i < 8; i++) addVec(4'(i), 1'b1, 0, 0, 0, 0, 8'h01, 12'h010 + 12'(i));
    addVec(4'h0, 1'b0, 0, 0, 1, 0, 8'h01, 12'h010);
    addVec(4'h1, 1'b0, 0, 0, 0, 1, 8'h01, 12'h011);
    addVec(4'h0, 1'b0, 0, 0, 0, 0, 8'h01, 12'h010);
    addVec(4'hF, 1'b0, 0, 1, 0, 0, 8'h00, 12'h00F);
    addVec(4'h0, 1'b0, 1, 0, 0, 1, 8'h01, 12'h010);
    addVec(4'h0, 1'b1, 0, 0, 0, 0, 8'h01, 12'h010);
    addVec(4'hF, 1'b1, 0, 1, 0, 1, 8'h00, 12'h00F);
    addVec(4'h1, 1'b1, 0, 0, 1, 0, 8'h00, 12'h001);

    #1;
    checkPulses("por", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("por valid", 32'(valid), 32'd0);
    checkOutput("por hi", 32'(hi_count), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("clocked in reset valid", 32'(valid), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("pre-init valid", 32'(valid), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].cnt, vecs[i].ud);
      checkPulses($sformatf("vec%0d", i), vecs[i].carry, vecs[i].borrow, vecs[i].step, vecs[i].dir);
      checkOutput($sformatf("vec%0d hi", i), 32'(hi_count), 32'(vecs[i].hi));
      checkOutput($sformatf("vec%0d full", i), 32'(full_count), 32'(vecs[i].full));
      checkOutput($sformatf("vec%0d valid", i), 32'(valid), 32'd1);
    end

    // Down sweep from a fresh hi_count of zero: borrow wraps hi to 0xFF.
    pulseReset(4'h1, 1'b0);
    applyStimulus(4'h1, 1'b0);
    checkOutput("down init full", 32'(full_count), 32'h001);
    checkOutput("down init valid", 32'(valid), 32'd1);
    applyStimulus(4'h0, 1'b0);
    checkPulses("down 1to0", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("down 1to0 full", 32'(full_count), 32'h000);
    applyStimulus(4'hF, 1'b0);
    checkPulses("down 0toF", 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("down 0toF hi", 32'(hi_count), 32'hFF);
    checkOutput("down 0toF full", 32'(full_count), 32'hFFF);
    applyStimulus(4'hE, 1'b0);
    checkPulses("down FtoE", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("down FtoE full", 32'(full_count), 32'hFFE);

    // Hold 0x5 for 16 samples (the INIT load is the first), then step to 0x6.
    pulseReset(4'h5, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(4'h5, 1'b1);
`ifdef COUNT_WRAP_TRACKER_STALL_EN
      checkOutput($sformatf("stall sample%0d", i), 32'(stalled), 32'(i == 16));
`else
      checkOutput($sformatf("stall sample%0d", i), 32'(stalled), 32'd0);
`endif
    end
    applyStimulus(4'h6, 1'b1);
    checkOutput("stall exit", 32'(stalled), 32'd0);
    checkPulses("stall exit", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("stall exit full", 32'(full_count), 32'h006);

    // Reset asserted the cycle after a carry clears everything without a clock.
    pulseReset(4'hE, 1'b1);
    applyStimulus(4'hE, 1'b1);
    applyStimulus(4'hF, 1'b1);
    applyStimulus(4'h0, 1'b1);
    checkOutput("midrst carry before", 32'(carry_out), 32'd1);
    checkOutput("midrst hi before", 32'(hi_count), 32'h01);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midrst carry", 32'(carry_out), 32'd0);
    checkOutput("midrst hi", 32'(hi_count), 32'd0);
    checkOutput("midrst valid", 32'(valid), 32'd0);
    #1;
    count_in = 4'h1;
    reset    = 1'b1;
    #1;
    checkOutput("midrst pre-init valid", 32'(valid), 32'd0);
    applyStimulus(4'h1, 1'b1);
    checkOutput("midrst init valid", 32'(valid), 32'd1);
    checkOutput("midrst init full", 32'(full_count), 32'h001);
    checkPulses("midrst init", 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'h2, 1'b1);
    checkPulses("midrst step", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst step full", 32'(full_count), 32'h002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_wrap_tracker.md
# count_wrap_tracker

Downstream consumer of the 4-bit up/down counter. Samples the counter's `count` output and `updown` control every clock. Detects wrap-around (0xF→0x0 carry, 0x0→0xF borrow) and extends the count with a high-order up/down counter into a wide composite value. Flags illegal steps and, optionally, a stalled counter for the display and monitor logic further down the datapath.

## Interface
- `HI_WIDTH`, 8: width of the high-order wrap counter.
- `STALL_LIMIT`, 16: consecutive unchanged samples before `stalled` asserts (≥2, ≤255).

- `clk`  in  1  rising-edge clock, shared with the counter.
- `reset`  in  1  asynchronous, active-low reset.
- `updown`  in  1  counter direction: 1 = up, 0 = down; same net that drives the counter.
- `count_in`  in  4  counter output.
- `carry_out`  out  1  one-cycle pulse on a 0xF→0x0 step.
- `borrow_out`  out  1  one-cycle pulse on a 0x0→0xF step.
- `step_err`  out  1  one-cycle pulse on any change that is not ±1 mod 16.
- `dir_err`  out  1  one-cycle pulse on a legal ±1 step whose direction disagrees with the previous-cycle `updown`.
- `hi_count`  out  HI_WIDTH  wrap counter.
- `full_count`  out  HI_WIDTH+4  `{hi_count, last sampled count}`.
- `valid`  out  1  high once the first sample after reset is taken.
- `stalled`  out  1  count unchanged for `STALL_LIMIT` samples.

## Operation
- Internal registers: `prev_q`[3:0], `dir_q` (previous `updown`), `hi_q`, `run_q`[7:0] (unchanged-sample counter), and a state register.
- FSM states:
  - INIT: no previous sample. The first edge loads `prev_q` and `dir_q`, sets `valid`, moves to TRACK, and evaluates no events.
  - TRACK: normal operation.
  - STALL: entered when `run_q` reaches `STALL_LIMIT-1` and the current sample is unchanged.
- Step classification on each edge in TRACK/STALL, with `d = count_in − prev_q` mod 16:
  - `d == 0`: no event. `run_q` increments, saturating.
  - `d == 1`: up step. Carry if `prev_q == 0xF`. `dir_err` if `dir_q == 0`.
  - `d == 15`: down step. Borrow if `prev_q == 0x0`. `dir_err` if `dir_q == 1`.
  - Any other `d`: `step_err`. No carry, no borrow, `hi_q` unchanged. This covers the upstream synchronous reset forcing 0 from a mid value.
  - Any nonzero `d` clears `run_q`.
  - The sample at every edge updates `prev_q` and `dir_q`.
- `hi_q` arithmetic:
  - Carry: +1 mod 2^HI_WIDTH. 0xFF wraps to 0x00 silently.
  - Borrow: −1 mod 2^HI_WIDTH. 0x00 wraps to 0xFF.
  - Carry and borrow are mutually exclusive by construction.
- STALL exits to TRACK on any nonzero `d`. That same sample is still classified normally, so a carry can occur on the exit edge.
- The direction check applies even to wrap steps: a 0xF→0x0 step with `dir_q == 0` pulses both `carry_out` and `dir_err`.

## Timing
- All outputs are registered. An event caused by `count_in` sampled at edge k is visible from edge k until edge k+1 (one-cycle pulse, latency 1 edge).
- `full_count` and `hi_count` update at the same edge as the corresponding pulse. They are always mutually consistent.
- Back-to-back steps (a count change every cycle) are fully supported with no lost events.
- Reset is asynchronous and active-low:
  - Effect while asserted: all outputs 0, `prev_q` = 0, `hi_q` = 0, `run_q` = 0, state INIT.
  - Deassertion: the first rising edge after deassertion is the INIT load.
  - Mid-operation: reset asserted mid-operation immediately drops any pulse in flight and clears `hi_count`.
- `stalled` rises on the edge that makes the unchanged run length equal `STALL_LIMIT`. It falls on the edge that samples a change.

## Configuration
- `COUNT_WRAP_TRACKER_STALL_EN`:
  - Defined: `run_q`, the STALL state, and the `stalled` output logic are compiled in as described above.
  - Undefined: the run counter is removed, `stalled` is tied to 0, and the FSM uses INIT/TRACK only. All other behaviour is identical.

## Test plan
- Reset, then hold `count_in` = 0x3:
  - `valid` = 0 until the first edge after `reset` rises, then 1.
  - All pulses stay 0.
  - `full_count` = 0x003.
- Up sweep 0x0…0xF, 0x0, 0x1 with `updown` = 1:
  - Exactly one `carry_out` pulse, in the cycle after 0x0 is sampled.
  - `hi_count` 0→1.
  - `full_count` = 0x010, then 0x011.
- Down sweep from 0x1 to 0xE with `updown` = 0 and `hi_count` = 0:
  - One `borrow_out` pulse.
  - `hi_count` = 0xFF, `full_count` = 0xFFF then 0xFFE.
  - No `dir_err`.
- `count_in` jumps 0x7→0x0, then 0x0→0x1 with `updown` = 0:
  - First jump: `step_err` pulse, `hi_count` unchanged.
  - 0x0→0x1 step: `dir_err` pulse.
- With the macro defined, hold `count_in` = 0x5 for 16 samples and then step to 0x6:
  - `stalled` asserts at the 16th sample.
  - It deasserts on the edge sampling 0x6.
  - Without the macro, `stalled` stays 0 throughout.
- During an up sweep, assert `reset` in the cycle after `carry_out` fires:
  - `carry_out`, `hi_count`, and `valid` drop to 0 immediately, without a clock.
  - Recovery via INIT after release.
